// File: rtl/rom_pkg.sv
// rtl/rom_pkg.sv - shared FSM encoding and default widths for the ROM burst reader
package rom_pkg;

  localparam int ROM_ADDR_W = 2;
  localparam int ROM_DATA_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } rd_state_e;

endpackage

// File: rtl/rom_4x4.sv
// rtl/rom_4x4.sv - 4x4 registered-read ROM (0,5,10,15); drives Z when no read is pending
module ROM_4x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] addr,
  output logic [3:0] data
);

  logic [3:0] q;
  logic       vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= 4'd0;
      vld <= 1'b0;
    end else begin
      vld <= en;
      if (en) begin
        case (addr)
          2'd0:    q <= 4'd0;
          2'd1:    q <= 4'd5;
          2'd2:    q <= 4'd10;
          default: q <= 4'd15;
        endcase
      end
    end
  end

  assign data = vld ? q : 4'bzzzz;

endmodule

// File: rtl/rom_reader_4x4.sv
// rtl/rom_reader_4x4.sv - issues a burst of ROM reads, hands each word to a ready/valid consumer
module rom_reader_4x4
  import rom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W+1:0] checksum
);

  // Largest burst equals the ROM depth.
  localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

  rd_state_e         state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W+1:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rom_en     = 1'b0;
    data_valid = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (count == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        rom_en    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: state_nxt = OUT;
      OUT: begin
        data_valid = 1'b1;
        if (data_ready) state_nxt = (remaining == 1) ? DONE : ISSUE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      data_q    <= '0;
      sum_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sum_q <= '0;
            if (count != '0) begin
              addr      <= start_addr;
              remaining <= (count > MAX_COUNT) ? MAX_COUNT : count;
            end
          end
        end
        // rom_data is only trusted here; it may float in every other state.
        WAIT: begin
          data_q <= rom_data;
          sum_q  <= sum_q + (DATA_W+2)'(rom_data);
        end
        OUT: begin
          if (data_ready) begin
            remaining <= remaining - 1'b1;
            if (remaining != 1) addr <= addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_addr = addr;
  assign data_out = data_q;
  assign checksum = sum_q;

endmodule

// File: tb/tb_rom_reader_4x4.sv
// tb/tb_rom_reader_4x4.sv - directed scoreboard bench for rom_reader_4x4 against ROM_4x4
module tb_rom_reader_4x4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] start_addr = 2'd0;
  logic [2:0] count = 3'd0;
  logic       rom_en;
  logic [1:0] rom_addr;
  wire  [3:0] rom_data;
  logic [3:0] data_out;
  logic       data_valid;
  logic       data_ready = 1'b1;
  logic       busy;
  logic       done;
  logic [5:0] checksum;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_q[$];
  logic [1:0] addr_log[$];
  int done_at, valid_at, en_cnt, excl_viol, stall_ok;

  always #5 clk = ~clk;

  rom_reader_4x4 #(.ADDR_W(2), .DATA_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .done(done), .checksum(checksum)
  );

  ROM_4x4 u_rom (.clk(clk), .rst(rst), .en(rom_en), .addr(rom_addr), .data(rom_data));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rom_word(input logic [1:0] a);
    case (a)
      2'd0:    return 4'd0;
      2'd1:    return 4'd5;
      2'd2:    return 4'd10;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] out_vec();
    return {18'd0, rom_en, rom_addr, data_out, data_valid, busy, done, checksum};
  endfunction

  // n counts falling edges after the one that raises start.
  task automatic burst(input logic [1:0] a, input logic [2:0] c, input int stall,
                       input int abort_at, input int restart_at);
    int eff;
    int left;
    logic [1:0] ad;
    logic [3:0] e;
    eff = (c > 3'd4) ? 4 : int'(c);
    for (int i = 0; i < eff; i++) begin
      ad = a + 2'(i);
      exp_q.push_back(rom_word(ad));
    end
    addr_log.delete();
    done_at = 0; valid_at = 0; en_cnt = 0; excl_viol = 0; stall_ok = 0;
    left = stall;
    @(negedge clk);
    start = 1'b1; start_addr = a; count = c;
    if (stall > 0) data_ready = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        start_addr = 2'($urandom);
        count = 3'($urandom);
      end
      if (restart_at > 0 && n == restart_at) begin
        start = 1'b1; start_addr = 2'd3; count = 3'd1;
      end
      if (restart_at > 0 && n == restart_at + 1) start = 1'b0;
      if (abort_at > 0 && n == abort_at) begin
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", out_vec(), 32'd0);
        return;
      end
      if (rom_en) begin
        en_cnt++;
        addr_log.push_back(rom_addr);
      end
      if (data_valid && valid_at == 0) valid_at = n;
      if (done && data_valid) excl_viol++;
      if (data_valid && left > 0) begin
        if (!rom_en && exp_q.size() > 0 && data_out === exp_q[0]) stall_ok++;
        left--;
        if (left == 0) data_ready = 1'b1;
      end
      if (data_valid && data_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("word", 32'(data_out), 32'(e));
        end
      end
      if (done) begin
        done_at = n;
        break;
      end
    end
    chk("done_seen", 32'(done_at != 0), 32'd1);
    chk("done_valid_exclusive", excl_viol, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    @(negedge clk);
    chk("reset_outputs", out_vec(), 32'd0);
    rst = 1'b0;

    // four words from address 0
    burst(2'd0, 3'd4, 0, 0, 0);
    chk("t1_first_valid", valid_at, 3);
    chk("t1_done_at", done_at, 13);
    chk("t1_rom_en_pulses", en_cnt, 4);
    chk("t1_addr3", (addr_log.size() == 4) ? 32'(addr_log[3]) : 32'hbad, 32'd3);
    chk("t1_checksum", 32'(checksum), 32'd30);

    // wrap from 3 to 0
    burst(2'd3, 3'd2, 0, 0, 0);
    chk("t2_addr0", (addr_log.size() == 2) ? 32'(addr_log[0]) : 32'hbad, 32'd3);
    chk("t2_addr1", (addr_log.size() == 2) ? 32'(addr_log[1]) : 32'hbad, 32'd0);
    chk("t2_done_at", done_at, 7);
    chk("t2_checksum", 32'(checksum), 32'd15);

    // consumer stall for five cycles
    burst(2'd1, 3'd1, 5, 0, 0);
    chk("t3_stall_held", stall_ok, 5);
    chk("t3_done_at", done_at, 8);
    chk("t3_rom_en_pulses", en_cnt, 1);
    chk("t3_checksum", 32'(checksum), 32'd5);

    // empty burst
    burst(2'd2, 3'd0, 0, 0, 0);
    chk("t4_rom_en_pulses", en_cnt, 0);
    chk("t4_done_at", done_at, 1);
    chk("t4_checksum", 32'(checksum), 32'd0);

    // oversized count saturates at four
    burst(2'd2, 3'd7, 0, 0, 0);
    chk("t5_rom_en_pulses", en_cnt, 4);
    chk("t5_done_at", done_at, 13);
    chk("t5_checksum", 32'(checksum), 32'd30);

    // reset during WAIT of the second word
    burst(2'd1, 3'd4, 0, 5, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    begin
      int activity;
      activity = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (done || busy || rom_en) activity++;
      end
      chk("t6_quiet_after_reset", activity, 0);
    end
    burst(2'd2, 3'd1, 0, 0, 0);
    chk("t6_done_at", done_at, 4);
    chk("t6_checksum", 32'(checksum), 32'd10);

    // start with other arguments while busy
    burst(2'd0, 3'd2, 0, 0, 4);
    chk("t7_rom_en_pulses", en_cnt, 2);
    chk("t7_addr1", (addr_log.size() == 2) ? 32'(addr_log[1]) : 32'hbad, 32'd1);
    chk("t7_done_at", done_at, 7);
    chk("t7_checksum", 32'(checksum), 32'd5);
    @(negedge clk);
    chk("t7_idle_after", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_reader_4x4.md
ROM_READER_4X4 -- requirements
Module: rom_reader_4x4

Interface
REQ-001 SHALL have parameter ADDR_W, default 2, ROM address width.
REQ-002 SHALL have parameter DATA_W, default 4, ROM word width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a read burst; sampled only in IDLE.
REQ-006 SHALL have port start_addr  input  ADDR_W  first ROM address of the burst.
REQ-007 SHALL have port count  input  ADDR_W+1  words to read, 0..4; sampled with start.
REQ-008 SHALL have port rom_en  output  1  read enable to ROM.
REQ-009 SHALL have port rom_addr  output  ADDR_W  address to ROM.
REQ-010 SHALL have port rom_data  input  DATA_W  ROM registered read data, valid 1 cycle after rom_en; may be Z otherwise.
REQ-011 SHALL have port data_out  output  DATA_W  captured word.
REQ-012 SHALL have port data_valid  output  1  data_out holds a word.
REQ-013 SHALL have port data_ready  input  1  consumer accepts word when high with data_valid.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at burst end.
REQ-016 SHALL have port checksum  output  DATA_W+2  modulo-2^(DATA_W+2) sum of burst words, held until the next start.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, OUT, DONE.
REQ-018 IDLE: start=1 and count>0 -> latch start_addr and count, clear checksum, go ISSUE; start=1 and count=0 -> clear checksum, go DONE.
REQ-019 ISSUE (one cycle): rom_en=1, rom_addr=current address; go WAIT.
REQ-020 WAIT (one cycle): rom_en=0; capture rom_data into data_out; add it to checksum; go OUT.
REQ-021 OUT: data_valid=1, data_out stable; on data_valid&data_ready, decrement remaining; if remaining was 1 go DONE, else increment address and go ISSUE.
REQ-022 DONE (one cycle): done=1; go IDLE.
REQ-023 Latency: start sampled at edge k -> data_valid high from cycle k+3; back-to-back words every 3 cycles with data_ready held high.
REQ-024 Address increment SHALL wrap modulo 2^ADDR_W (3 -> 0).
REQ-025 rom_en SHALL be high only in ISSUE; rom_data SHALL be sampled only in WAIT (Z elsewhere ignored).
REQ-026 start while busy SHALL be ignored; start_addr/count changes while busy SHALL have no effect.
REQ-027 count values above 4 SHALL be saturated to 4.
REQ-028 data_ready low in OUT SHALL stall indefinitely with data_out, data_valid unchanged and rom_en=0.
REQ-029 done and data_valid SHALL never be high in the same cycle.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, rom_en=0, rom_addr=0, data_out=0, data_valid=0, busy=0, done=0, checksum=0, internal counters=0.
REQ-031 rst asserted mid-burst SHALL abandon the burst with no done pulse; operation resumes only on a new start after rst deasserts.

Structure
REQ-032 FSM state encoding typedef and default ADDR_W/DATA_W constants SHALL live in shared package rom_pkg.
REQ-033 Single module, no sub-modules; bench SHALL instantiate ROM_4x4 (contents 0,5,10,15) as the responder.

Verification
REQ-034 start_addr=0, count=4, data_ready=1 -> words 0,5,10,15 in order, done one cycle after last accept, checksum=30.
REQ-035 start_addr=3, count=2 -> words 15 then 0 (wrap), rom_addr sequence 3,0, checksum=15.
REQ-036 start_addr=1, count=1, data_ready low 5 cycles -> data_out=5 held with data_valid=1 for 5 cycles, rom_en stays 0, then accept and done.
REQ-037 count=0 -> no rom_en pulse, done one cycle after start, checksum=0; count=7 -> exactly 4 words.
REQ-038 rst pulsed during WAIT of second word -> all outputs 0 asynchronously, no done; new start addr=2,count=1 -> word 10, checksum=10.
REQ-039 start reasserted with different args mid-burst -> ignored; first burst output unchanged.
